// File: rtl/llr_pkg.sv
// Shared definitions for the LLR sign-conversion datapath.
//
// Contents:
//   MODE_*   - runtime conversion mode encodings carried with every beat
//   llr_min  - most-negative two's-complement value of a given width,
//              returned zero-extended in 64 bits (callers slice [W-1:0])
package llr_pkg;

    localparam logic [1:0] MODE_CNEG  = 2'd0;  // negate lanes selected by cneg
    localparam logic [1:0] MODE_ABS   = 2'd1;  // absolute value
    localparam logic [1:0] MODE_TC2SM = 2'd2;  // two's-complement -> sign-magnitude
    localparam logic [1:0] MODE_SM2TC = 2'd3;  // sign-magnitude -> two's-complement

    // -2^(w-1) as a w-bit pattern: only the top bit set.
    function automatic logic [63:0] llr_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/llr_lane_neg.sv
// Combinational per-lane negate / saturate / format stage.
//
// Ports:
//   a    in  W  registered lane value from S1
//   mode in  2  conversion mode of the beat
//   neg  in  1  negate decision made in S1
//   r    out W  converted lane value
//   ovf  out 1  the negated operand was -2^(W-1)
module llr_lane_neg
    import llr_pkg::*;
#(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [1:0]   mode,
    input  logic         neg,
    output logic [W-1:0] r,
    output logic         ovf
);

    localparam logic [63:0]  MIN64 = llr_min(W);
    localparam logic [W-1:0] VMIN  = MIN64[W-1:0];
    localparam logic [W-1:0] VMAX  = ~VMIN;

    logic [W-1:0] v;
    logic [W-1:0] negv;
    logic [W-1:0] sel;

    always_comb begin
        // SM2TC works on the zero-extended magnitude, so its operand can
        // never be VMIN and it never raises ovf.
        v    = (mode == MODE_SM2TC) ? {1'b0, a[W-2:0]} : a;
        negv = -v;
        ovf  = neg && (v == VMIN);

        if (!neg)
            sel = v;
        else if (ovf)
            sel = SAT ? VMAX : VMIN;
        else
            sel = negv;

        // TC2SM: sign bit is the original sign, magnitude field is the low
        // bits of |a| (all-ones when saturating, zero when wrapping VMIN).
        r = (mode == MODE_TC2SM) ? {neg, sel[W-2:0]} : sel;
    end

endmodule

// File: rtl/llr_cneg_pipe.sv
// Multi-lane conditional-negate / sign-conversion unit, 2-stage
// valid/ready pipeline (S1 captures operands and negate decision, S2
// holds converted lanes and drives the outputs).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is combinational
//   in_data  [N*W]      lane i at [i*W +: W]
//   in_cneg  [N]        per-lane negate control (CNEG mode only)
//   in_mode  [2]        conversion mode, travels with the beat
//   out_valid/out_ready output handshake
//   out_data [N*W]      converted lanes, same packing as in_data
//   out_ovf  [N]        lane was -2^(W-1) and got negated
//   cnt_clr             synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt  [CW]       saturating count of accepted beats with any ovf
module llr_cneg_pipe
    import llr_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter bit SAT = 1'b1,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_cneg,
    input  logic [1:0]     in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_ovf,
    input  logic           cnt_clr,
    output logic [CW-1:0]  ovf_cnt
);

    typedef struct packed {
        logic [N-1:0][W-1:0] a;
        logic [1:0]          mode;
        logic [N-1:0]        neg;
    } s1_t;

    typedef struct packed {
        logic [N-1:0][W-1:0] r;
        logic [N-1:0]        ovf;
    } s2_t;

    // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid
    logic [2:1] vld_pipe;
    logic       s1_adv;
    logic       s2_adv;

    logic [N-1:0][W-1:0] in_lane;
    logic [N-1:0]        neg_d;
    s1_t                 s1_d, s1_q;
    s2_t                 s2_d, s2_q;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !vld_pipe[2] || out_ready;
    assign s1_adv   = !vld_pipe[1] || s2_adv;
    assign in_ready = s1_adv;

    assign in_lane = in_data;

    // S1 negate decision per lane
    for (genvar i = 0; i < N; i++) begin : g_neg
        assign neg_d[i] = (in_mode == MODE_CNEG) ? in_cneg[i] : in_lane[i][W-1];
    end

    always_comb begin
        s1_d      = '0;
        s1_d.a    = in_lane;
        s1_d.mode = in_mode;
        s1_d.neg  = neg_d;
    end

    // S2 lane converters
    for (genvar i = 0; i < N; i++) begin : g_lane
        llr_lane_neg #(
            .W   (W),
            .SAT (SAT)
        ) u_lane (
            .a    (s1_q.a[i]),
            .mode (s1_q.mode),
            .neg  (s1_q.neg[i]),
            .r    (s2_d.r[i]),
            .ovf  (s2_d.ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid)
                    s1_q <= s1_d;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1])
                    s2_q <= s2_d;
            end
        end
    end

    assign out_valid = vld_pipe[2];
    assign out_data  = s2_q.r;
    assign out_ovf   = s2_q.ovf;

    // Overflow event counter: one count per accepted beat, saturating.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            ovf_cnt <= '0;
        else if (out_valid && out_ready && (|out_ovf) && (ovf_cnt != {CW{1'b1}}))
            ovf_cnt <= ovf_cnt + CW'(1);
    end

endmodule

// File: tb/tb_llr_cneg_pipe.sv
module tb_llr_cneg_pipe;
    import llr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_cneg;
    logic [1:0]  in_mode;
    logic        out_ready;
    logic        cnt_clr;

    // u0: SAT=1 CW=16, u1: SAT=0 CW=16, u2: SAT=1 CW=4 (shared stimulus)
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [31:0] d0, d1, d2;
    logic [3:0]  f0, f1, f2;
    logic [15:0] c0, c1;
    logic [3:0]  c2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    llr_cneg_pipe #(.W(8), .N(4), .SAT(1'b1), .CW(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .in_cneg(in_cneg), .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready),
        .out_data(d0), .out_ovf(f0), .cnt_clr(cnt_clr), .ovf_cnt(c0));
    llr_cneg_pipe #(.W(8), .N(4), .SAT(1'b0), .CW(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_cneg(in_cneg), .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready),
        .out_data(d1), .out_ovf(f1), .cnt_clr(cnt_clr), .ovf_cnt(c1));
    llr_cneg_pipe #(.W(8), .N(4), .SAT(1'b1), .CW(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .in_cneg(in_cneg), .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready),
        .out_data(d2), .out_ovf(f2), .cnt_clr(cnt_clr), .ovf_cnt(c2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backpressure stream: beat k, lane i = 16k+i+1, mode k%4, cneg all ones.
    function automatic logic [31:0] bp_data(input int k);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(16*k + i + 1);
        return d;
    endfunction

    function automatic logic [31:0] bp_exp(input int k);
        logic [31:0] d;
        logic [7:0]  v;
        for (int i = 0; i < 4; i++) begin
            v = 8'(16*k + i + 1);
            d[i*8 +: 8] = ((k % 4) == 0) ? 8'(0 - int'(v)) : v;
        end
        return d;
    endfunction

    // One isolated beat: checks acceptance, 2-cycle latency, data, ovf, counters.
    task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] cn,
                        input logic [1:0] m, input logic [31:0] e_sat, input logic [31:0] e_wrap,
                        input logic [3:0] e_ovf);
        in_valid = 1'b1; in_data = d; in_cneg = cn; in_mode = m;
        #1;
        check({tag, ".in_ready"}, 64'(ir0), 64'd1);
        step();
        in_valid = 1'b0; in_data = 32'hDEADBEEF; in_cneg = 4'hA; in_mode = 2'd1;
        check({tag, ".lat1_valid"}, 64'(ov0), 64'd0);
        step();
        check({tag, ".lat2_valid"}, 64'(ov0), 64'd1);
        check({tag, ".data_sat"}, 64'(d0), 64'(e_sat));
        check({tag, ".data_wrap"}, 64'(d1), 64'(e_wrap));
        check({tag, ".data_cw4"}, 64'(d2), 64'(e_sat));
        check({tag, ".ovf_sat"}, 64'(f0), 64'(e_ovf));
        check({tag, ".ovf_wrap"}, 64'(f1), 64'(e_ovf));
        if (e_ovf != 4'd0) begin
            exp_cnt++;
            if (exp_cnt2 < 15) exp_cnt2++;
        end
        step();
        check({tag, ".drained"}, 64'(ov0), 64'd0);
        check({tag, ".cnt"}, 64'(c0), 64'(exp_cnt));
        check({tag, ".cnt_cw4"}, 64'(c2), 64'(exp_cnt2));
    endtask

    initial begin
        int sent, got;
        logic acc, take;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cneg = '0; in_mode = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        step(); step();
        check("rst.out_valid", 64'(ov0), 64'd0);
        check("rst.out_data", 64'(d0), 64'd0);
        check("rst.out_ovf", 64'(f0), 64'd0);
        check("rst.ovf_cnt", 64'(c0), 64'd0);
        check("rst.in_ready", 64'({ir0, ir1, ir2}), 64'b111);
        rst = 1'b0;
        step();

        // lanes listed lane3..lane0
        beat("cneg", 32'h007F8005, 4'b1111, MODE_CNEG, 32'h00817FFB, 32'h008180FB, 4'b0010);
        beat("abs", 32'hFF800AF6, 4'b0000, MODE_ABS, 32'h017F0A0A, 32'h01800A0A, 4'b0100);
        beat("tc2sm", 32'h008003FD, 4'b0000, MODE_TC2SM, 32'h00FF0383, 32'h00800383, 4'b0100);
        beat("sm2tc", 32'h7F800383, 4'b0000, MODE_SM2TC, 32'h7F0003FD, 32'h7F0003FD, 4'b0000);
        beat("cneg_mix", 32'h80800505, 4'b0101, MODE_CNEG, 32'h807F05FB, 32'h808005FB, 4'b0100);

        // Backpressure: 6 back-to-back beats, out_ready low for 5 edges.
        sent = 0; got = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (cyc == 5) out_ready = 1'b1;
            in_valid = (sent < 6);
            in_data  = bp_data(sent);
            in_mode  = 2'(sent % 4);
            in_cneg  = 4'b1111;
            #1;
            acc  = in_valid && ir0;
            take = ov0 && out_ready;
            if (cyc >= 2 && cyc < 5) begin
                check("bp.stall_in_ready", 64'(ir0), 64'd0);
                check("bp.stall_accepted", 64'(sent), 64'd2);
                check("bp.stall_data", 64'(d0), 64'(bp_exp(0)));
            end
            if (take) check("bp.order", 64'(d0), 64'(bp_exp(got)));
            step();
            if (acc) sent++;
            if (take) got++;
        end
        in_valid = 1'b0;
        check("bp.sent", 64'(sent), 64'd6);
        check("bp.got", 64'(got), 64'd6);
        check("bp.no_dup", 64'(ov0), 64'd0);

        // Counter saturation: 14 ovf beats at full rate.
        in_data = 32'h80808080; in_cneg = 4'b1111; in_mode = MODE_CNEG;
        for (int k = 0; k < 14; k++) begin
            in_valid = 1'b1;
            #1;
            check("sat.in_ready", 64'(ir0), 64'd1);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        exp_cnt += 14;
        exp_cnt2 = 15;
        check("sat.cnt16", 64'(c0), 64'(exp_cnt));
        check("sat.cnt4_hold", 64'(c2), 64'(exp_cnt2));

        // cnt_clr coinciding with an ovf beat accept.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        cnt_clr = 1'b1;
        #1;
        check("clr.ovf_beat", 64'(ov0 && (f0 != 4'd0)), 64'd1);
        step();
        cnt_clr = 1'b0;
        exp_cnt = 0; exp_cnt2 = 0;
        check("clr.cnt16", 64'(c0), 64'd0);
        check("clr.cnt4", 64'(c2), 64'd0);
        beat("post_clr", 32'h80000000, 4'b1000, MODE_CNEG, 32'h7F000000, 32'h80000000, 4'b1000);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h80808080; in_cneg = 4'b1111; in_mode = MODE_CNEG;
        step(); step();
        in_valid = 1'b0;
        check("mid.full", 64'(ov0), 64'd1);
        rst = 1'b1;
        step();
        check("mid.out_valid", 64'(ov0), 64'd0);
        check("mid.out_data", 64'(d0), 64'd0);
        check("mid.ovf_cnt", 64'(c0), 64'd0);
        check("mid.in_ready", 64'(ir0), 64'd1);
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("mid.no_stale", 64'(ov0), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/llr_cneg_pipe.md
Name: llr_cneg_pipe

Overview:
- Parametrised, pipelined multi-lane conditional-negate / sign-conversion unit for LLR datapaths in the polar decoder.
- Successor to the 8-bit combinational conditional negator. Generalised in:
  - width and lane count;
  - four runtime modes: conditional negate, absolute value, two's-complement to sign-magnitude, sign-magnitude to two's-complement;
  - optional saturation and per-lane overflow flags;
  - a valid/ready handshaked 2-stage pipeline.
- Sits between channel LLR input buffering and the f/g node processing elements.

Parameters:
- W, 8, bits per LLR lane (>=2)
- N, 4, lanes processed per beat (>=1)
- SAT, 1, 1 = negating -2^(W-1) clamps to 2^(W-1)-1; 0 = two's-complement wrap
- CW, 16, width of overflow event counter

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  N*W  lane i at [i*W +: W]
- in_cneg  in  N  per-lane negate control, used in mode 0 only
- in_mode  in  2  0=CNEG, 1=ABS, 2=TC2SM, 3=SM2TC; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  N*W  converted lanes, same packing as in_data
- out_ovf  out  N  per-lane flag: lane value was -2^(W-1) and was negated
- cnt_clr  in  1  synchronous clear of ovf_cnt
- ovf_cnt  out  CW  count of accepted output beats with any out_ovf bit set

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - both stage-valid bits = 0, so out_valid = 0;
  - out_data = 0, out_ovf = 0, ovf_cnt = 0;
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards in-flight beats with no output.
- Pipeline structure: two register stages, S1 and S2 (S2 drives the outputs).
  - Latency: 2 cycles from accept to out_valid when unstalled.
  - Throughput: 1 beat/clk.
- Handshake:
  - s2_adv = !s2_v || out_ready
  - s1_adv = !s1_v || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer required).
  - Outputs hold stable while out_valid && !out_ready.
  - in_data is ignored when in_valid = 0.
- S1 (registers input lane a, mode, and per-lane neg decision):
  - CNEG: neg = in_cneg[i]
  - ABS: neg = a[W-1]
  - TC2SM: neg = a[W-1]
  - SM2TC: neg = a[W-1]; the magnitude is {1'b0, a[W-2:0]}
- S2 (per lane, on value v = a, or the zero-extended magnitude in SM2TC):
  - CNEG / ABS: r = neg ? -v : v
  - TC2SM: mag = neg ? -v : v; out = {neg, mag[W-2:0]}
  - SM2TC: out = neg ? -mag : mag. Negative zero (100..0) outputs 0, no ovf.
- Overflow rule:
  - ovf[i] = 1 only when the negated operand equals -2^(W-1).
  - Only CNEG, ABS and TC2SM can hit this; SM2TC never sets ovf.
  - SAT=1: result = 2^(W-1)-1; in TC2SM the output is {1, all-ones magnitude}.
  - SAT=0: result = -2^(W-1) (wrap); in TC2SM the magnitude field is 0.
  - ovf is reported in both SAT settings.
- Counter ovf_cnt:
  - increments by 1 on out_valid && out_ready && |out_ovf;
  - saturates at 2^CW-1;
  - cnt_clr forces 0 and wins over a simultaneous increment;
  - rst clears it.
- Mode change between consecutive beats has no bubble; each beat carries its own mode.
- Lanes are fully independent, with no cross-lane carry.

Decomposition:
- Shared package llr_pkg:
  - mode constants MODE_CNEG=2'd0, MODE_ABS=2'd1, MODE_TC2SM=2'd2, MODE_SM2TC=2'd3;
  - helper for the most-negative constant of width W.
- One natural sub-module: llr_lane_neg, the combinational per-lane negate/saturate/format.
  - Parameters W and SAT.
  - Instantiated N times by a generate loop inside the S2 logic.

Test Plan:
- W=8, N=4, SAT=1, CNEG, in_data lanes {0x05,0x80,0x7F,0x00}, in_cneg=4'b1111 -> out {0xFB,0x7F,0x81,0x00}, out_ovf=4'b0010, ovf_cnt=1, out_valid exactly 2 cycles after accept.
- ABS, lanes {0xF6,0x0A,0x80,0xFF}, SAT=0 build -> out {0x0A,0x0A,0x80,0x01}, out_ovf=4'b0100; SAT=1 build -> lane 2 = 0x7F.
- TC2SM on {0xFD,0x03,0x80,0x00} (SAT=1) -> {0x83,0x03,0xFF,0x00}; SM2TC on {0x83,0x03,0x80,0x7F} -> {0xFD,0x03,0x00,0x7F}, ovf=0.
- Backpressure:
  - stream 6 beats with continuous in_valid;
  - hold out_ready=0 for 5 cycles -> in_ready drops after 2 beats are accepted;
  - out_data is stable throughout the stall;
  - on release all 6 beats emerge in order with none lost or duplicated.
- Counter:
  - preset ovf_cnt near saturation (CW=4, 16 ovf beats) -> holds at 15;
  - cnt_clr asserted in the same cycle as an ovf beat accept -> ovf_cnt=0.
- Reset mid-stream:
  - assert rst with S1 and S2 full -> next cycle out_valid=0, out_data=0, ovf_cnt=0, in_ready=1;
  - no stale beat appears afterwards.
